bcd_serial_add_ctrl: RTL and testbench

Sequencer that performs a multi-digit packed-BCD addition by time-sharing one external single-digit decimal adder (4-bit a/b, cin in; 4-bit s, cout out; purely combinational).
The block latches two DIGITS-wide BCD operands on a start pulse and feeds the adder one digit per clock, least-significant digit first. It ripples the carry through a register and assembles the result.
It sits between the operand source (switch/keypad capture logic) and the display or result register, with a start/busy/done handshake.

---
 rtl/bcd_serial_add_ctrl.sv | 123 ++++++++++++
 tb/tb_bcd_serial_add_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_add_ctrl.sv
// rtl/bcd_serial_add_ctrl.sv - multi-digit packed-BCD adder sequencer over one shared digit adder
// Feeds the external decimal adder one digit per clock, LSD first, rippling carry through a register.
module bcd_serial_add_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a_bcd,
  input  logic [4*DIGITS-1:0]   b_bcd,
  input  logic                  cin,
  output logic [3:0]            add_a,
  output logic [3:0]            add_b,
  output logic                  add_cin,
  input  logic [3:0]            add_s,
  input  logic                  add_cout,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  err
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nx;
  logic [W-1:0]  a_q, b_q;
  logic [IW-1:0] idx;
  logic          carry;
  logic [3:0]    dig_a, dig_b;
  logic          bad;

  always_comb begin
    dig_a = '0;
    dig_b = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        dig_a = a_q[4*i +: 4];
        dig_b = b_q[4*i +: 4];
      end
    end
  end

  // Operand screening happens on the raw inputs at the accepting edge.
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a_bcd[4*i +: 4] > 4'd9 || b_bcd[4*i +: 4] > 4'd9) bad = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    add_a    = 4'd0;
    add_b    = 4'd0;
    add_cin  = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = bad ? DONE : RUN;
      end
      RUN: begin
        busy    = 1'b1;
        add_a   = dig_a;
        add_b   = dig_b;
        add_cin = carry;
        if (idx == LAST) state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      idx   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a_bcd;
            b_q   <= b_bcd;
            idx   <= '0;
            carry <= cin;
            sum   <= '0;
            cout  <= 1'b0;
            err   <= bad;
          end
        end
        RUN: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) sum[4*i +: 4] <= add_s;
          end
          carry <= add_cout;
          if (idx == LAST) cout <= add_cout;
          else             idx  <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// tb/tb_bcd_serial_add_ctrl.sv - self-checking bench for bcd_serial_add_ctrl
// Decimal reference model plus a behavioural single-digit adder on the shared-adder port.
module tb_bcd_serial_add_ctrl;

  localparam int D = 4;
  localparam int W = 4 * D;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_bcd, b_bcd;
  logic         cin;
  logic [3:0]   add_a, add_b, add_s;
  logic         add_cin, add_cout;
  logic         busy, done, cout, err;
  logic [W-1:0] sum;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bcd_serial_add_ctrl #(.DIGITS(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a_bcd(a_bcd), .b_bcd(b_bcd), .cin(cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .err(err)
  );

  logic [4:0] add_t;
  always_comb begin
    add_t = 5'(add_a) + 5'(add_b) + 5'(add_cin);
    if (add_t > 5'd9) begin
      add_s    = 4'(add_t - 5'd10);
      add_cout = 1'b1;
    end else begin
      add_s    = add_t[3:0];
      add_cout = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned p10(input int d);
    int unsigned r = 1;
    for (int i = 0; i < d; i++) r = r * 10;
    return r;
  endfunction

  function automatic int unsigned val(input logic [W-1:0] v);
    int unsigned r = 0;
    for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int unsigned x);
    logic [W-1:0] r = '0;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic bit has_bad(input logic [W-1:0] v);
    bit b = 1'b0;
    for (int i = 0; i < D; i++) if (v[4*i +: 4] > 4'd9) b = 1'b1;
    return b;
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] r;
    for (int i = 0; i < D; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  // One full operation; leaves start high afterwards when hold is set.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input bit hold);
    int unsigned tot, cin_d;
    logic [W-1:0] es;
    logic ec;
    bit bad;
    bad = has_bad(a) || has_bad(b);
    es = '0;
    ec = 1'b0;
    if (!bad) begin
      tot = val(a) + val(b) + int'(c);
      es  = to_bcd(tot % p10(D));
      ec  = (tot >= p10(D));
    end
    @(negedge clk);
    a_bcd = a; b_bcd = b; cin = c; start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    a_bcd = W'($urandom);
    b_bcd = W'($urandom);
    cin   = 1'($urandom);
    check("busy_accept", 32'(busy), 32'd1);
    check("sum_cleared", 32'(sum), 32'd0);
    if (!bad) begin
      for (int d = 0; d < D; d++) begin
        cin_d = ((val(a) % p10(d)) + (val(b) % p10(d)) + int'(c) >= p10(d)) ? 1 : 0;
        check($sformatf("add_a_d%0d", d), 32'(add_a), 32'(a[4*d +: 4]));
        check($sformatf("add_b_d%0d", d), 32'(add_b), 32'(b[4*d +: 4]));
        check($sformatf("add_cin_d%0d", d), 32'(add_cin), cin_d);
        check("done_low_run", 32'(done), 32'd0);
        @(posedge clk); #1;
      end
    end
    check("done_pulse", 32'(done), 32'd1);
    check("busy_done", 32'(busy), 32'd1);
    check("sum", 32'(sum), 32'(es));
    check("cout", 32'(cout), 32'(ec));
    check("err", 32'(err), 32'(bad));
    check("add_a_idle", 32'(add_a), 32'd0);
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    check("sum_held", 32'(sum), 32'(es));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    rst_n = 1'b0; start = 1'b0; a_bcd = '0; b_bcd = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_flags", {30'd0, cout, err}, 32'd0);
    check("rst_add", {23'd0, add_a, add_b, add_cin}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    do_op(16'h1234, 16'h5678, 1'b0, 1'b0);
    do_op(16'h9999, 16'h0001, 1'b0, 1'b0);
    do_op(16'h9999, 16'h9999, 1'b1, 1'b0);
    do_op(16'h12A4, 16'h0000, 1'b0, 1'b0);
    do_op(16'h0000, 16'h0000, 1'b1, 1'b0);

    // start held high through an operation with changing operands
    do_op(16'h0005, 16'h0007, 1'b0, 1'b1);
    do_op(16'h4321, 16'h1111, 1'b1, 1'b0);

    // reset during RUN after two digits
    @(negedge clk);
    a_bcd = 16'h1234; b_bcd = 16'h5678; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) @(posedge clk);
    #2; rst_n = 1'b0; #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_add", {23'd0, add_a, add_b, add_cin}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("abort_no_done", 32'(done), 32'd0);
    end
    do_op(16'h0808, 16'h0303, 1'b0, 1'b0);

    for (int n = 0; n < 12; n++) begin
      ra = rand_bcd();
      rb = rand_bcd();
      if ($urandom_range(0, 3) == 0) ra[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
      do_op(ra, rb, 1'($urandom), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
